// File: rtl/nios2_bus_input_scanner.sv
// Round-robin scanner for four sources sharing one 8-bit input bus, exposed as an Avalon-MM slave.
// Optional build macro NIOS2_BUSINPUT_SYNC_EN adds a 2-flop synchronizer on src_data.
module nios2_bus_input_scanner #(
    parameter int unsigned NUM_SRC       = 4,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [7:0]  src_data,
    output logic [1:0]  src_sel,
    output logic        irq
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CNT_W  = 9;
`ifdef NIOS2_BUSINPUT_SYNC_EN
    localparam int unsigned SETTLE_LEN = SETTLE_CYCLES + 2;
`else
    localparam int unsigned SETTLE_LEN = SETTLE_CYCLES;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SEL_W-1:0]       src_sel_q, src_sel_d;
    logic [DATA_W-1:0]      value_q [NUM_SRC];
    logic [DATA_W-1:0]      value_d [NUM_SRC];
    logic [NUM_SRC-1:0]     changed_q, changed_d;
    logic                   scan_en_q, scan_en_d;
    logic                   irq_en_q, irq_en_d;
    logic                   irq_q, irq_d;
    logic [31:0]            readdata_q, readdata_d;
    logic [DATA_W-1:0]      sample_data_c;
    logic                   unused_wdata_c;

    assign unused_wdata_c = &{1'b0, writedata[31:NUM_SRC]};

`ifdef NIOS2_BUSINPUT_SYNC_EN
    logic [DATA_W-1:0] sync1_q, sync2_q;

    // Two-stage synchronizer for the asynchronous board input bus
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src_data;
            sync2_q <= sync1_q;
        end
    end

    assign sample_data_c = sync2_q;
`else
    assign sample_data_c = src_data;
`endif

    // Next-state: bus writes first, then scan FSM so a hardware change-set overrides W1C
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        src_sel_d  = src_sel_q;
        value_d    = value_q;
        changed_d  = changed_q;
        scan_en_d  = scan_en_q;
        irq_en_d   = irq_en_q;
        irq_d      = irq_en_q & (|changed_q);
        readdata_d = '0;

        if (write && (address == 3'd5)) begin
            scan_en_d = writedata[0];
            irq_en_d  = writedata[1];
        end
        if (write && (address == 3'd4)) begin
            changed_d = changed_q & ~writedata[NUM_SRC-1:0];
        end

        case (state_q)
            IDLE: begin
                if (scan_en_q) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_LEN - 1)) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                value_d[src_sel_q] = sample_data_c;
                if (sample_data_c != value_q[src_sel_q]) begin
                    changed_d[src_sel_q] = 1'b1;
                end
                src_sel_d = src_sel_q + SEL_W'(1);
                if (scan_en_q) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (address)
            3'd0, 3'd1, 3'd2, 3'd3: readdata_d = 32'(value_q[address[1:0]]);
            3'd4:                   readdata_d = 32'(changed_q);
            3'd5:                   readdata_d = 32'({irq_en_q, scan_en_q});
            3'd6:                   readdata_d = 32'({(state_q != IDLE), 6'b0, src_sel_q});
            default:                readdata_d = '0;
        endcase
    end

    // State and register file
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= SETTLE;
            cnt_q      <= '0;
            src_sel_q  <= '0;
            changed_q  <= '0;
            scan_en_q  <= 1'b1;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                value_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            src_sel_q  <= src_sel_d;
            changed_q  <= changed_d;
            scan_en_q  <= scan_en_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
            for (int i = 0; i < NUM_SRC; i++) begin
                value_q[i] <= value_d[i];
            end
        end
    end

    assign readdata = readdata_q;
    assign src_sel  = src_sel_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_nios2_bus_input_scanner.sv
// Self-checking bench for nios2_bus_input_scanner: register reads go through an expected-value queue.
module tb_nios2_bus_input_scanner;

    localparam int unsigned SETTLE = 4;
`ifdef NIOS2_BUSINPUT_SYNC_EN
    localparam int unsigned SLOT = SETTLE + 3;
`else
    localparam int unsigned SLOT = SETTLE + 1;
`endif

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  src_data;
    logic [1:0]  src_sel;
    logic        irq;
    logic [7:0]  vals [4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[7];

    nios2_bus_input_scanner #(.NUM_SRC(4), .SETTLE_CYCLES(SETTLE)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .src_data  (src_data),
        .src_sel   (src_sel),
        .irq       (irq)
    );

    // Board input mux: the selected source drives the shared bus
    assign src_data = vals[src_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic rd(input string name, input logic [2:0] a, input logic [31:0] exp);
        exp_t e;
        @(negedge clk);
        address = a;
        e.name  = name;
        e.exp   = exp;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check(e.name, readdata, e.exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(posedge clk);
        #1;
        write = 1'b0;
    endtask

    task automatic wait_sel(input logic [1:0] t, input string name);
        int n = 0;
        while (src_sel !== t && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(src_sel), 32'(t));
    endtask

    // Returns #1 after the edge on which src_sel newly becomes t
    task automatic wait_enter(input logic [1:0] t, input string name);
        int n = 0;
        while (src_sel === t && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        wait_sel(t, name);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] prev;
        logic [1:0] nxt;

        vecs[0] = '{3'd0, 32'h11, "rot_value0"};
        vecs[1] = '{3'd1, 32'h22, "rot_value1"};
        vecs[2] = '{3'd2, 32'h33, "rot_value2"};
        vecs[3] = '{3'd3, 32'h44, "rot_value3"};
        vecs[4] = '{3'd7, 32'h0,  "rot_addr7"};
        vecs[5] = '{3'd4, 32'hF,  "rot_changed"};
        vecs[6] = '{3'd5, 32'h1,  "rot_control"};

        reset_n   = 1'b0;
        write     = 1'b0;
        address   = 3'd0;
        writedata = '0;
        vals[0] = 8'h5A; vals[1] = 8'h00; vals[2] = 8'h00; vals[3] = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        check("reset_readdata", readdata, 32'h0);
        check("reset_src_sel", 32'(src_sel), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);

        // First slot after reset release: capture at edge SLOT, visible at SLOT+1
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= SLOT + 1; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("first_sel_e%0d", e), 32'(src_sel), (e >= SLOT) ? 32'h1 : 32'h0);
            check($sformatf("first_rd_e%0d", e), readdata, (e >= SLOT + 1) ? 32'h5A : 32'h0);
        end
        rd("first_changed", 3'd4, 32'h1);

        // Full rotation with distinct values; every src_sel step must be +1 mod 4
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        prev = src_sel;
        repeat (4 * SLOT + 5) begin
            @(posedge clk);
            #1;
            if (src_sel !== prev) begin
                nxt = prev + 2'd1;
                check("sel_step", 32'(src_sel), 32'(nxt));
                prev = src_sel;
            end
        end
        for (int i = 0; i < 7; i++) begin
            rd(vecs[i].name, vecs[i].addr, vecs[i].exp);
        end

        // Stop scanning mid-SETTLE on source 2: slot still completes, then IDLE at src_sel 3
        wr(3'd4, 32'hF);
        wait_enter(2'd2, "wait_src2");
        vals[2] = 8'h99;
        @(posedge clk);
        wr(3'd5, 32'h2);
        wait_sel(2'd3, "wait_src3_after_stop");
        repeat (2) @(posedge clk);
        rd("status_idle", 3'd6, 32'h3);
        rd("value2_last", 3'd2, 32'h99);
        check("irq_idle", 32'(irq), 32'h1);
        repeat (3 * SLOT) @(posedge clk);
        #1;
        check("sel_held", 32'(src_sel), 32'h3);
        wr(3'd4, 32'hF);
        @(posedge clk);
        #1;
        check("irq_cleared_idle", 32'(irq), 32'h0);

        // Source 1 goes 0x00 -> 0x80 with irq enabled
        vals[1] = 8'h00;
        wr(3'd5, 32'h1);
        wait_enter(2'd2, "wait_src1_zero");
        wr(3'd4, 32'hF);
        vals[1] = 8'h80;
        wr(3'd5, 32'h3);
        wait_enter(2'd1, "wait_src1_slot");
        wait_sel(2'd2, "wait_src1_sample");
        check("irq_same_edge", 32'(irq), 32'h0);
        @(posedge clk);
        #1;
        check("irq_next_edge", 32'(irq), 32'h1);
        rd("changed_src1", 3'd4, 32'h2);
        wr(3'd4, 32'h2);
        rd("changed_cleared", 3'd4, 32'h0);
        check("irq_cleared", 32'(irq), 32'h0);

        // W1C of changed[3] on the very edge source 3 samples a new value: set wins
        wait_enter(2'd3, "wait_src3_collide");
        vals[3] = 8'h55;
        repeat (SLOT - 1) @(posedge clk);
        wr(3'd4, 32'h8);
        check("sel_at_collision", 32'(src_sel), 32'h0);
        rd("changed3_set_wins", 3'd4, 32'h8);
        rd("value3_collision", 3'd3, 32'h55);

        // Reset asserted during SAMPLE of source 2 discards the capture
        wait_enter(2'd2, "wait_src2_reset");
        vals[2] = 8'h77;
        repeat (SLOT - 1) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset_readdata", readdata, 32'h0);
        check("midreset_src_sel", 32'(src_sel), 32'h0);
        check("midreset_irq", 32'(irq), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        address = 3'd0;
        reset_n = 1'b1;
        for (int e = 1; e <= SLOT + 1; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("rerun_sel_e%0d", e), 32'(src_sel), (e >= SLOT) ? 32'h1 : 32'h0);
            check($sformatf("rerun_rd_e%0d", e), readdata, (e >= SLOT + 1) ? 32'h11 : 32'h0);
        end
        rd("value2_after_reset", 3'd2, 32'h0);
        rd("changed_after_reset", 3'd4, 32'h1);
        rd("ctrl_after_reset", 3'd5, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
